mem_request_queue: RTL and testbench

Pipeline-side request front end for `lockup_free_cache`. It buffers load/store requests from the datapath in a small FIFO and issues the head to the cache one per cycle, honouring `stall`. It tracks every miss by the UUID the cache returns and reports a completion to the pipeline when the owning bank raises `block_status`. It also sequences the halt/flush handshake so that `dp_in_halt` is only raised once all traffic has drained.

---
 rtl/cache_types_pkg.sv | 40 ++++
 rtl/mem_request_queue_if.sv | 27 ++
 rtl/mrq_fifo.sv | 46 ++++
 rtl/mem_request_queue.sv | 185 ++++++++++++++++++
 tb/tb_mem_request_queue.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_types_pkg.sv
// Shared cache geometry plus the request-queue payload, tracking and state types.
package cache_types_pkg;

  localparam int unsigned NUM_BANKS         = 4;
  localparam int unsigned UUID_SIZE         = 4;
  localparam int unsigned BANKS_LEN         = 2;
  localparam int unsigned BYTE_OFF_BIT_LEN  = 2;
  localparam int unsigned BLOCK_OFF_BIT_LEN = 4;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;

  // Bit position of the bank index within a request address
  localparam int unsigned BANK_LSB = BYTE_OFF_BIT_LEN + BLOCK_OFF_BIT_LEN;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] store;
    logic [TAG_W-1:0]  tag;
  } mrq_entry_t;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [UUID_SIZE-1:0] uuid;
    logic [BANKS_LEN-1:0] bank;
    logic [TAG_W-1:0]     tag;
    logic                 rw;
  } mrq_track_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } mrq_state_e;

endpackage

// File: rtl/mem_request_queue_if.sv
// Pipeline-side request/response bundle of the memory request queue.
interface mem_request_queue_if;
  import cache_types_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [DATA_W-1:0] req_store;
  logic [TAG_W-1:0]  req_tag;

  logic              resp_valid;
  logic [TAG_W-1:0]  resp_tag;
  logic [DATA_W-1:0] resp_data;
  logic              resp_replay;

  modport master (
    output req_valid, req_addr, req_rw, req_store, req_tag,
    input  req_ready, resp_valid, resp_tag, resp_data, resp_replay
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_store, req_tag,
    output req_ready, resp_valid, resp_tag, resp_data, resp_replay
  );

endinterface

// File: rtl/mrq_fifo.sv
// Synchronous FIFO with full/empty flags; push while full is accepted only with a pop.
module mrq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_request_queue.sv
// Request front end for lockup_free_cache: queues pipeline requests, issues the head,
// tracks misses by UUID, returns completions and sequences the halt/flush handshake.
module mem_request_queue
  import cache_types_pkg::*;
#(
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned OUTSTANDING = 8
) (
  input  logic                                CLK,
  input  logic                                nRST,
  mem_request_queue_if.slave                  pipe,
  input  logic                                halt_req,
  output logic                                halt_done,
  output logic                                err_unmatched,
  output logic                                mem_in,
  output logic [ADDR_W-1:0]                   mem_in_addr,
  output logic                                mem_in_rw_mode,
  output logic [DATA_W-1:0]                   mem_in_store_value,
  output logic                                dp_in_halt,
  input  logic                                stall,
  input  logic                                hit,
  input  logic [DATA_W-1:0]                   hit_load,
  input  logic [UUID_SIZE-1:0]                mem_out_uuid,
  input  logic [NUM_BANKS-1:0]                block_status,
  input  logic [NUM_BANKS-1:0][UUID_SIZE-1:0] uuid_block,
  input  logic                                dp_out_flushed
);

  localparam int unsigned IDX_W = $clog2(OUTSTANDING);

  mrq_entry_t push_data;
  mrq_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       req_ready;

  mrq_track_t tbl_q [OUTSTANDING];
  mrq_track_t tbl_d [OUTSTANDING];

  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic                   done_found;
  logic [IDX_W-1:0]       done_idx;
  logic                   any_valid;
  logic                   tbl_full;
  logic [OUTSTANDING-1:0] set_done;
  logic [NUM_BANKS-1:0]   bank_match;
  logic                   unmatched;

  logic       hit_resp;
  logic       alloc;
  logic       drain;
  logic       alive_q;
  logic       err_q;
  mrq_state_e state_q;
  mrq_state_e state_d;

  assign push_data = '{addr: pipe.req_addr, rw: pipe.req_rw,
                       store: pipe.req_store, tag: pipe.req_tag};
  assign req_ready = alive_q && !fifo_full && (state_q == RUN);
  assign fifo_push = pipe.req_valid && req_ready;
  assign pipe.req_ready = req_ready;

  mrq_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(mrq_entry_t))
  ) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (fifo_push),
    .pop   (mem_in),
    .din   (push_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lowest free slot, lowest completed slot and occupancy of the tracking table
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    done_found = 1'b0;
    done_idx   = '0;
    any_valid  = 1'b0;
    for (int j = OUTSTANDING - 1; j >= 0; j--) begin
      if (!tbl_q[j].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(j);
      end
      if (tbl_q[j].valid && tbl_q[j].done) begin
        done_found = 1'b1;
        done_idx   = IDX_W'(j);
      end
      if (tbl_q[j].valid) any_valid = 1'b1;
    end
  end

  assign tbl_full = !free_found;

  // Per-bank completion matcher, all banks in parallel
  always_comb begin
    set_done   = '0;
    bank_match = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      for (int j = 0; j < OUTSTANDING; j++) begin
        if (block_status[i] && tbl_q[j].valid && !tbl_q[j].done &&
            (tbl_q[j].bank == BANKS_LEN'(i)) && (tbl_q[j].uuid == uuid_block[i])) begin
          set_done[j]   = 1'b1;
          bank_match[i] = 1'b1;
        end
      end
    end
  end

  assign unmatched = |(block_status & ~bank_match);

  // Issue from FIFO head; hit responses take the response slot over completions
  assign mem_in             = !fifo_empty && !stall && !tbl_full &&
                              ((state_q == RUN) || (state_q == DRAIN));
  assign mem_in_addr        = head.addr;
  assign mem_in_rw_mode     = head.rw;
  assign mem_in_store_value = head.store;
  assign hit_resp           = mem_in && hit;
  assign alloc              = mem_in && !hit;
  assign drain              = !hit_resp && done_found;

  assign pipe.resp_valid  = hit_resp || drain;
  assign pipe.resp_tag    = hit_resp ? head.tag : tbl_q[done_idx].tag;
  assign pipe.resp_data   = hit_resp ? hit_load : '0;
  assign pipe.resp_replay = !hit_resp && drain && !tbl_q[done_idx].rw;

  // Table next state: free drained entry, mark completions, allocate on miss
  always_comb begin
    for (int j = 0; j < OUTSTANDING; j++) begin
      tbl_d[j] = tbl_q[j];
      if (drain && (done_idx == IDX_W'(j))) tbl_d[j] = '0;
      if (set_done[j]) tbl_d[j].done = 1'b1;
      if (alloc && (free_idx == IDX_W'(j))) begin
        tbl_d[j] = '{valid: 1'b1, done: 1'b0, uuid: mem_out_uuid,
                     bank: head.addr[BANK_LSB +: BANKS_LEN],
                     tag: head.tag, rw: head.rw};
      end
    end
  end

  // Tracking table register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int j = 0; j < OUTSTANDING; j++) tbl_q[j] <= '0;
    end else begin
      for (int j = 0; j < OUTSTANDING; j++) tbl_q[j] <= tbl_d[j];
    end
  end

  // Halt sequencing next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !any_valid) state_d = FLUSH;
      FLUSH:   if (dp_out_flushed) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // State, sticky error and post-reset ready enable
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q || unmatched;
      alive_q <= 1'b1;
    end
  end

  assign err_unmatched = err_q;
  assign dp_in_halt    = (state_q == FLUSH) || (state_q == DONE);
  assign halt_done     = (state_q == DONE);

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue with hand-computed expectations.
module tb_mem_request_queue;
  import cache_types_pkg::*;

  logic                                CLK;
  logic                                nRST;
  logic                                halt_req;
  logic                                halt_done;
  logic                                err_unmatched;
  logic                                mem_in;
  logic [ADDR_W-1:0]                   mem_in_addr;
  logic                                mem_in_rw_mode;
  logic [DATA_W-1:0]                   mem_in_store_value;
  logic                                dp_in_halt;
  logic                                stall;
  logic                                hit;
  logic [DATA_W-1:0]                   hit_load;
  logic [UUID_SIZE-1:0]                mem_out_uuid;
  logic [NUM_BANKS-1:0]                block_status;
  logic [NUM_BANKS-1:0][UUID_SIZE-1:0] uuid_block;
  logic                                dp_out_flushed;

  int errors = 0;
  int checks = 0;

  mem_request_queue_if pipe ();

  mem_request_queue #(.QDEPTH(4), .OUTSTANDING(8)) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .pipe               (pipe),
    .halt_req           (halt_req),
    .halt_done          (halt_done),
    .err_unmatched      (err_unmatched),
    .mem_in             (mem_in),
    .mem_in_addr        (mem_in_addr),
    .mem_in_rw_mode     (mem_in_rw_mode),
    .mem_in_store_value (mem_in_store_value),
    .dp_in_halt         (dp_in_halt),
    .stall              (stall),
    .hit                (hit),
    .hit_load           (hit_load),
    .mem_out_uuid       (mem_out_uuid),
    .block_status       (block_status),
    .uuid_block         (uuid_block),
    .dp_out_flushed     (dp_out_flushed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_req(input logic [31:0] addr, input logic rw,
                          input logic [31:0] store, input logic [3:0] tag);
    pipe.req_valid = 1'b1;
    pipe.req_addr  = addr;
    pipe.req_rw    = rw;
    pipe.req_store = store;
    pipe.req_tag   = tag;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"},  32'(pipe.req_ready),  32'd0);
    chk({pfx, "_mem_in"},     32'(mem_in),          32'd0);
    chk({pfx, "_resp_valid"}, 32'(pipe.resp_valid), 32'd0);
    chk({pfx, "_dp_in_halt"}, 32'(dp_in_halt),      32'd0);
    chk({pfx, "_halt_done"},  32'(halt_done),       32'd0);
    chk({pfx, "_err"},        32'(err_unmatched),   32'd0);
  endtask

  initial begin
    nRST = 1'b0;
    pipe.req_valid = 1'b0; pipe.req_addr = '0; pipe.req_rw = 1'b0;
    pipe.req_store = '0;   pipe.req_tag = '0;
    halt_req = 1'b0; stall = 1'b0; hit = 1'b0; hit_load = '0;
    mem_out_uuid = '0; block_status = '0; uuid_block = '0; dp_out_flushed = 1'b0;

    // Reset values
    #3;
    chk_reset_outputs("rst");
    #10 nRST = 1'b1;
    tick();
    chk("ready_after_reset", 32'(pipe.req_ready), 32'd1);

    // Hit: load 0x100 tag 3
    push_req(32'h100, 1'b0, 32'h0, 4'd3);
    hit = 1'b1; hit_load = 32'hDEADBEEF;
    tick();
    pipe.req_valid = 1'b0;
    #1;
    chk("hit_mem_in",   32'(mem_in),           32'd1);
    chk("hit_addr",     mem_in_addr,           32'h100);
    chk("hit_valid",    32'(pipe.resp_valid),  32'd1);
    chk("hit_tag",      32'(pipe.resp_tag),    32'd3);
    chk("hit_data",     pipe.resp_data,        32'hDEADBEEF);
    chk("hit_replay",   32'(pipe.resp_replay), 32'd0);
    tick();
    hit = 1'b0;
    #1;
    chk("hit_idle", 32'(mem_in), 32'd0);

    // Miss: load 0x40 tag 5, uuid 2 on bank 1
    push_req(32'h40, 1'b0, 32'h0, 4'd5);
    tick();
    pipe.req_valid = 1'b0; mem_out_uuid = 4'd2;
    #1;
    chk("miss_mem_in", 32'(mem_in),          32'd1);
    chk("miss_noresp", 32'(pipe.resp_valid), 32'd0);
    tick();
    mem_out_uuid = 4'd0; block_status = 4'b0010; uuid_block[1] = 4'd2;
    #1;
    chk("miss_comp_cycle", 32'(pipe.resp_valid), 32'd0);
    tick();
    block_status = '0;
    #1;
    chk("miss_resp_valid",  32'(pipe.resp_valid),  32'd1);
    chk("miss_resp_tag",    32'(pipe.resp_tag),    32'd5);
    chk("miss_resp_data",   pipe.resp_data,        32'd0);
    chk("miss_resp_replay", 32'(pipe.resp_replay), 32'd1);
    tick();
    #1;
    chk("miss_freed", 32'(pipe.resp_valid), 32'd0);

    // Stall with a full FIFO, then four back-to-back hit issues
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_req(32'h300 + 32'(k * 4), (k == 2), 32'hA0 + 32'(k), 4'(8 + k));
      #1;
      chk("stall_push_ready", 32'(pipe.req_ready), 32'd1);
      tick();
    end
    pipe.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_mem_in", 32'(mem_in),         32'd0);
      chk("stall_full",   32'(pipe.req_ready), 32'd0);
      tick();
    end
    stall = 1'b0; hit = 1'b1; hit_load = 32'h5555AAAA;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("burst_mem_in", 32'(mem_in),        32'd1);
      chk("burst_tag",    32'(pipe.resp_tag), 32'(8 + k));
      chk("burst_rw",     32'(mem_in_rw_mode), (k == 2) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("burst_empty", 32'(mem_in), 32'd0);
    hit = 1'b0;

    // Two misses (bank 0 load, bank 2 store), completions together, then a hit
    push_req(32'h000, 1'b0, 32'h0, 4'd1);
    tick();
    push_req(32'h080, 1'b1, 32'h77, 4'd2);
    mem_out_uuid = 4'd1;
    #1;
    chk("pair_a_issue", 32'(mem_in), 32'd1);
    tick();
    pipe.req_valid = 1'b0; mem_out_uuid = 4'd3;
    #1;
    chk("pair_b_addr", mem_in_addr, 32'h080);
    tick();
    push_req(32'h200, 1'b0, 32'h0, 4'd6);
    block_status = 4'b0101; uuid_block[0] = 4'd1; uuid_block[2] = 4'd3;
    #1;
    chk("pair_comp_noresp", 32'(pipe.resp_valid), 32'd0);
    tick();
    pipe.req_valid = 1'b0; block_status = '0; hit = 1'b1; hit_load = 32'h12345678;
    #1;
    chk("pair_hit_tag",  32'(pipe.resp_tag), 32'd6);
    chk("pair_hit_data", pipe.resp_data,     32'h12345678);
    tick();
    hit = 1'b0;
    #1;
    chk("pair_first_tag",    32'(pipe.resp_tag),    32'd1);
    chk("pair_first_replay", 32'(pipe.resp_replay), 32'd1);
    tick();
    #1;
    chk("pair_second_valid",  32'(pipe.resp_valid),  32'd1);
    chk("pair_second_tag",    32'(pipe.resp_tag),    32'd2);
    chk("pair_second_replay", 32'(pipe.resp_replay), 32'd0);
    tick();
    #1;
    chk("pair_done", 32'(pipe.resp_valid), 32'd0);

    // Halt with two misses outstanding (bank 3 uuid 4, bank 1 uuid 5)
    push_req(32'h0C0, 1'b0, 32'h0, 4'd7);
    tick();
    push_req(32'h040, 1'b0, 32'h0, 4'd4);
    mem_out_uuid = 4'd4;
    tick();
    pipe.req_valid = 1'b0; mem_out_uuid = 4'd5;
    tick();
    halt_req = 1'b1;
    tick();
    #1;
    chk("halt_ready",   32'(pipe.req_ready), 32'd0);
    chk("halt_dp_pend", 32'(dp_in_halt),     32'd0);
    block_status = 4'b1000; uuid_block[3] = 4'd4;
    tick();
    block_status = '0;
    #1;
    chk("halt_d_tag", 32'(pipe.resp_tag), 32'd7);
    tick();
    #1;
    chk("halt_dp_one_left", 32'(dp_in_halt), 32'd0);
    block_status = 4'b0010; uuid_block[1] = 4'd5;
    tick();
    block_status = '0;
    #1;
    chk("halt_e_tag", 32'(pipe.resp_tag), 32'd4);
    tick();
    #1;
    chk("halt_dp_drain", 32'(dp_in_halt), 32'd0);
    tick();
    #1;
    chk("halt_flush_dp",   32'(dp_in_halt), 32'd1);
    chk("halt_flush_done", 32'(halt_done),  32'd0);
    dp_out_flushed = 1'b1;
    tick();
    dp_out_flushed = 1'b0;
    #1;
    chk("halt_done",    32'(halt_done),  32'd1);
    chk("halt_done_dp", 32'(dp_in_halt), 32'd1);
    tick();
    #1;
    chk("halt_done_held", 32'(halt_done), 32'd1);

    // Unknown uuid 7 on bank 3 sets sticky error
    chk("err_before", 32'(err_unmatched), 32'd0);
    block_status = 4'b1000; uuid_block[3] = 4'd7;
    tick();
    block_status = '0;
    #1;
    chk("err_set", 32'(err_unmatched), 32'd1);
    tick();
    #1;
    chk("err_sticky", 32'(err_unmatched), 32'd1);

    // Reset pulse clears halt state and error
    halt_req = 1'b0;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("rst2");
    #2 nRST = 1'b1;
    tick();

    // Reset mid-traffic: one outstanding miss, one queued request
    push_req(32'h040, 1'b0, 32'h0, 4'd9);
    tick();
    push_req(32'h100, 1'b0, 32'h0, 4'd10);
    mem_out_uuid = 4'd6;
    #1;
    chk("mid_issue", 32'(mem_in), 32'd1);
    tick();
    pipe.req_valid = 1'b0; stall = 1'b1;
    #1;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("rst3");
    #1 nRST = 1'b1;
    stall = 1'b0;
    tick();
    #1;
    chk("post_ready",  32'(pipe.req_ready),  32'd1);
    chk("post_mem_in", 32'(mem_in),          32'd0);
    chk("post_resp",   32'(pipe.resp_valid), 32'd0);
    block_status = 4'b0010; uuid_block[1] = 4'd6;
    tick();
    block_status = '0;
    #1;
    chk("post_table_cleared", 32'(err_unmatched), 32'd1);
    chk("post_no_resp",       32'(pipe.resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
